// File: rtl/axi_reorder_checker_pkg.sv
// Shared types for the AXI reorder checker: error causes, counter width and
// default AXI channel/request/response structs used when no types are supplied.
package axi_reorder_checker_pkg;

  localparam int unsigned AvailCntWidth = 16;
  localparam logic [1:0]  RespDecerr    = 2'b11;

  typedef enum logic [2:0] {
    ErrNoOutstanding,
    ErrNotYetProduced,
    ErrBadLen,
    ErrBadDecerr,
    ErrOverflow
  } err_cause_e;
  localparam int unsigned NumErrCauses = 5;

  typedef logic [31:0] axi_addr_t;

  typedef struct packed {
    logic [31:0] idx;
    axi_addr_t   start_addr;
    axi_addr_t   end_addr;
  } axi_rule_t;

  typedef struct packed {
    logic [3:0] id;
    axi_addr_t  addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } axi_ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } axi_w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } axi_b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } axi_r_chan_t;

  typedef struct packed {
    axi_ax_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ax_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    axi_b_chan_t b;
    logic        b_valid;
    logic        ar_ready;
    axi_r_chan_t r;
    logic        r_valid;
  } axi_rsp_t;

endpackage

// File: rtl/axi_reorder_id_tracker.sv
// One FIFO per AXI ID holding outstanding-transaction entries; head, empty and
// full are reported for the IDs currently addressed by the pop and push ports.
module axi_reorder_id_tracker #(
  parameter type         entry_t = logic,
  parameter int unsigned IdWidth = 4,
  parameter int unsigned Depth   = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic [IdWidth-1:0] push_id_i,
  input  entry_t             push_data_i,
  input  logic               pop_i,
  input  logic [IdWidth-1:0] pop_id_i,
  output entry_t             head_o,
  output logic               empty_o,
  output logic               full_o,
  output logic               all_empty_o
);
  localparam int unsigned NumIds = 2**IdWidth;
  localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW   = $clog2(Depth + 1);

  logic [NumIds-1:0] empty_vec, full_vec;
  entry_t            head_vec [NumIds];

  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar i = 0; i < NumIds; i++) begin : g_id
    entry_t          mem [Depth];
    logic [PtrW-1:0] wr_ptr, rd_ptr;
    logic [CntW-1:0] cnt;
    logic            do_push, do_pop;

    // A push into a full FIFO is dropped; the top flags it as an overflow.
    assign do_push     = push_i && (push_id_i == IdWidth'(i)) && !full_vec[i];
    assign do_pop      = pop_i && (pop_id_i == IdWidth'(i)) && !empty_vec[i];
    assign empty_vec[i] = (cnt == '0);
    assign full_vec[i]  = (cnt == CntW'(Depth));
    assign head_vec[i]  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (do_push) begin
          mem[wr_ptr] <= push_data_i;
          wr_ptr      <= nxt(wr_ptr);
        end
        if (do_pop) rd_ptr <= nxt(rd_ptr);
        if (do_push != do_pop) cnt <= do_push ? cnt + 1'b1 : cnt - 1'b1;
      end
    end
  end

  assign head_o      = head_vec[pop_id_i];
  assign empty_o     = empty_vec[pop_id_i];
  assign full_o      = full_vec[push_id_i];
  assign all_empty_o = &empty_vec;

endmodule

// File: rtl/axi_reorder_checker.sv
// Passive scoreboard: B/R responses must reach the manager in per-ID issue
// order, only after the addressed subordinate produced them, with correct length.
module axi_reorder_checker
  import axi_reorder_checker_pkg::*;
#(
  parameter int unsigned NumSlaves      = 4,
  parameter int unsigned AxiIdWidth     = 4,
  parameter int unsigned NumAddrRegions = 4,
  parameter type         addr_t         = axi_addr_t,
  parameter type         rule_t         = axi_rule_t,
  parameter rule_t [NumAddrRegions-1:0] AddrRegions = '0,
  parameter type         aw_chan_t      = axi_ax_chan_t,
  parameter type         w_chan_t       = axi_w_chan_t,
  parameter type         b_chan_t       = axi_b_chan_t,
  parameter type         ar_chan_t      = axi_ax_chan_t,
  parameter type         r_chan_t       = axi_r_chan_t,
  parameter type         req_t          = axi_req_t,
  parameter type         rsp_t          = axi_rsp_t,
  parameter int unsigned MaxTxnsPerId   = 32,
  parameter int unsigned IdleCycles     = 100,
  parameter int unsigned Verbose        = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  req_t                       mon_mst_req_i,
  input  rsp_t                       mon_mst_rsp_i,
  input  req_t [NumSlaves-1:0]       mon_slv_req_i,
  input  rsp_t [NumSlaves-1:0]       mon_slv_rsp_i,
  output logic                       end_of_sim_o,
  output logic                       error_o,
  output logic [31:0]                err_cnt_o
);
  localparam int unsigned IdxW   = $clog2(NumSlaves + 1);
  localparam int unsigned NumIds = 2**AxiIdWidth;

  typedef logic [IdxW-1:0] idx_t;
  typedef struct packed {
    idx_t       idx;
    logic [7:0] len;
  } r_entry_t;

  aw_chan_t mst_aw;
  ar_chan_t mst_ar;
  b_chan_t  mst_b;
  r_chan_t  mst_r;
  w_chan_t  unused_w;
  logic     unused_bits;

  assign mst_aw      = mon_mst_req_i.aw;
  assign mst_ar      = mon_mst_req_i.ar;
  assign mst_b       = mon_mst_rsp_i.b;
  assign mst_r       = mon_mst_rsp_i.r;
  assign unused_w    = mon_mst_req_i.w;
  assign unused_bits = ^{mon_mst_req_i, mon_mst_rsp_i, mon_slv_req_i, mon_slv_rsp_i, Verbose};

  function automatic idx_t decode(input addr_t addr);
    idx_t res = idx_t'(NumSlaves);
    for (int k = NumAddrRegions - 1; k >= 0; k--)
      if (addr >= AddrRegions[k].start_addr && addr <= AddrRegions[k].end_addr)
        res = idx_t'(AddrRegions[k].idx);
    return res;
  endfunction

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, mst_hs;
  assign aw_hs  = mon_mst_req_i.aw_valid && mon_mst_rsp_i.aw_ready;
  assign w_hs   = mon_mst_req_i.w_valid  && mon_mst_rsp_i.w_ready;
  assign b_hs   = mon_mst_rsp_i.b_valid  && mon_mst_req_i.b_ready;
  assign ar_hs  = mon_mst_req_i.ar_valid && mon_mst_rsp_i.ar_ready;
  assign r_hs   = mon_mst_rsp_i.r_valid  && mon_mst_req_i.r_ready;
  assign mst_hs = aw_hs || w_hs || b_hs || ar_hs || r_hs;

  idx_t     w_head;
  r_entry_t r_head;
  logic     w_empty, w_full, w_all_empty, r_empty, r_full, r_all_empty;

  axi_reorder_id_tracker #(.entry_t(idx_t), .IdWidth(AxiIdWidth), .Depth(MaxTxnsPerId)) u_wtrk (
    .clk_i, .rst_ni,
    .push_i(aw_hs), .push_id_i(AxiIdWidth'(mst_aw.id)), .push_data_i(decode(mst_aw.addr)),
    .pop_i(b_hs), .pop_id_i(AxiIdWidth'(mst_b.id)),
    .head_o(w_head), .empty_o(w_empty), .full_o(w_full), .all_empty_o(w_all_empty)
  );

  axi_reorder_id_tracker #(.entry_t(r_entry_t), .IdWidth(AxiIdWidth), .Depth(MaxTxnsPerId)) u_rtrk (
    .clk_i, .rst_ni,
    .push_i(ar_hs), .push_id_i(AxiIdWidth'(mst_ar.id)),
    .push_data_i('{idx: decode(mst_ar.addr), len: mst_ar.len}),
    .pop_i(r_hs && mst_r.last), .pop_id_i(AxiIdWidth'(mst_r.id)),
    .head_o(r_head), .empty_o(r_empty), .full_o(r_full), .all_empty_o(r_all_empty)
  );

  logic [NumSlaves-1:0][AvailCntWidth-1:0] b_avail, r_avail;
  logic [NumSlaves-1:0]                    b_inc, r_inc, b_dec, r_dec;
  logic [NumIds-1:0][7:0]                  beat_cnt;
  logic [AvailCntWidth-1:0]                b_sel, r_sel;
  logic [7:0]                              r_beat;
  logic [NumErrCauses-1:0]                 b_errs, r_errs;
  logic [3:0]                              err_inc;
  logic [31:0]                             idle_cnt;
  logic                                    done_any;

  for (genvar s = 0; s < NumSlaves; s++) begin : g_slv
    assign b_inc[s] = mon_slv_rsp_i[s].b_valid && mon_slv_req_i[s].b_ready;
    assign r_inc[s] = mon_slv_rsp_i[s].r_valid && mon_slv_req_i[s].r_ready && mon_slv_rsp_i[s].r.last;
  end

  // Availability checks use the registered count, so a same-cycle subordinate
  // response cannot satisfy a manager response.
  always_comb begin
    b_errs = '0;
    r_errs = '0;
    b_dec  = '0;
    r_dec  = '0;
    b_sel  = '0;
    r_sel  = '0;
    r_beat = beat_cnt[mst_r.id];
    for (int s = 0; s < NumSlaves; s++) begin
      if (w_head == idx_t'(s))     b_sel = b_avail[s];
      if (r_head.idx == idx_t'(s)) r_sel = r_avail[s];
    end
    if (b_hs) begin
      if (w_empty) b_errs[ErrNoOutstanding] = 1'b1;
      else if (w_head == idx_t'(NumSlaves)) begin
        if (mst_b.resp != RespDecerr) b_errs[ErrBadDecerr] = 1'b1;
      end else if (b_sel == '0) b_errs[ErrNotYetProduced] = 1'b1;
      else
        for (int s = 0; s < NumSlaves; s++) b_dec[s] = (w_head == idx_t'(s));
    end
    if (r_hs) begin
      if (r_empty) r_errs[ErrNoOutstanding] = 1'b1;
      else if (mst_r.last) begin
        if (r_beat != r_head.len) r_errs[ErrBadLen] = 1'b1;
        if (r_head.idx == idx_t'(NumSlaves)) begin
          if (mst_r.resp != RespDecerr) r_errs[ErrBadDecerr] = 1'b1;
        end else if (r_sel == '0) r_errs[ErrNotYetProduced] = 1'b1;
        else
          for (int s = 0; s < NumSlaves; s++) r_dec[s] = (r_head.idx == idx_t'(s));
      end else if (r_beat == r_head.len) r_errs[ErrBadLen] = 1'b1;
    end
    err_inc = 4'($countones(b_errs)) + 4'($countones(r_errs))
            + 4'(aw_hs && w_full) + 4'(ar_hs && r_full);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      b_avail      <= '0;
      r_avail      <= '0;
      beat_cnt     <= '0;
      err_cnt_o    <= '0;
      error_o      <= 1'b0;
      idle_cnt     <= '0;
      done_any     <= 1'b0;
      end_of_sim_o <= 1'b0;
    end else begin
      for (int s = 0; s < NumSlaves; s++) begin
        if (b_inc[s] && !b_dec[s] && b_avail[s] != '1) b_avail[s] <= b_avail[s] + 1'b1;
        else if (b_dec[s] && !b_inc[s])                 b_avail[s] <= b_avail[s] - 1'b1;
        if (r_inc[s] && !r_dec[s] && r_avail[s] != '1) r_avail[s] <= r_avail[s] + 1'b1;
        else if (r_dec[s] && !r_inc[s])                 r_avail[s] <= r_avail[s] - 1'b1;
      end
      if (r_hs && !r_empty) begin
        if (mst_r.last)                    beat_cnt[mst_r.id] <= '0;
        else if (r_beat != 8'hFF)          beat_cnt[mst_r.id] <= r_beat + 1'b1;
      end
      if (err_inc != '0) begin
        error_o   <= 1'b1;
        err_cnt_o <= ({1'b0, err_cnt_o} + 33'(err_inc) > 33'hFFFF_FFFF)
                     ? '1 : err_cnt_o + 32'(err_inc);
      end
      if ((b_hs && !w_empty) || (r_hs && mst_r.last && !r_empty)) done_any <= 1'b1;
      if (mst_hs)                idle_cnt <= '0;
      else if (idle_cnt != '1)   idle_cnt <= idle_cnt + 1'b1;
      if (aw_hs || ar_hs) end_of_sim_o <= 1'b0;
      else if (!mst_hs && ({1'b0, idle_cnt} + 33'd1 >= 33'(IdleCycles))
               && w_all_empty && r_all_empty && done_any)
        end_of_sim_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_reorder_checker.sv
// Directed bench for axi_reorder_checker: ordering, length, DECERR, overflow,
// same-cycle availability, end-of-sim timing and reset.
module tb_axi_reorder_checker;
  import axi_reorder_checker_pkg::*;

  localparam axi_rule_t [3:0] Regions = '{
    '{idx: 32'd3, start_addr: 32'h0030_0000, end_addr: 32'h003F_FFFF},
    '{idx: 32'd2, start_addr: 32'h0020_0000, end_addr: 32'h002F_FFFF},
    '{idx: 32'd1, start_addr: 32'h0010_0000, end_addr: 32'h001F_FFFF},
    '{idx: 32'd0, start_addr: 32'h0000_0000, end_addr: 32'h000F_FFFF}
  };

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  axi_req_t        mst_req;
  axi_rsp_t        mst_rsp;
  axi_req_t [3:0]  slv_req;
  axi_rsp_t [3:0]  slv_rsp;
  logic            end_of_sim, error;
  logic [31:0]     err_cnt;
  int              total = 0;
  int              bad = 0;

  always #5 clk = ~clk;

  axi_reorder_checker #(.AddrRegions(Regions)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .mon_mst_req_i(mst_req), .mon_mst_rsp_i(mst_rsp),
    .mon_slv_req_i(slv_req), .mon_slv_rsp_i(slv_rsp),
    .end_of_sim_o(end_of_sim), .error_o(error), .err_cnt_o(err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic mst_aw(input logic [3:0] id, input logic [31:0] addr);
    mst_req.aw.id = id; mst_req.aw.addr = addr; mst_req.aw_valid = 1'b1;
    tick();
    mst_req.aw_valid = 1'b0;
  endtask

  task automatic mst_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    mst_req.ar.id = id; mst_req.ar.addr = addr; mst_req.ar.len = len; mst_req.ar_valid = 1'b1;
    tick();
    mst_req.ar_valid = 1'b0;
  endtask

  task automatic mst_b(input logic [3:0] id, input logic [1:0] resp);
    mst_rsp.b.id = id; mst_rsp.b.resp = resp; mst_rsp.b_valid = 1'b1;
    tick();
    mst_rsp.b_valid = 1'b0;
  endtask

  task automatic mst_r(input logic [3:0] id, input logic last);
    mst_rsp.r.id = id; mst_rsp.r.last = last; mst_rsp.r.resp = 2'b00; mst_rsp.r_valid = 1'b1;
    tick();
    mst_rsp.r_valid = 1'b0;
  endtask

  task automatic slv_b(input int s);
    slv_rsp[s].b_valid = 1'b1;
    tick();
    slv_rsp[s].b_valid = 1'b0;
  endtask

  task automatic slv_r_last(input int s);
    slv_rsp[s].r.last = 1'b1; slv_rsp[s].r_valid = 1'b1;
    tick();
    slv_rsp[s].r_valid = 1'b0;
  endtask

  initial begin
    mst_req = '0; mst_rsp = '0; slv_req = '0; slv_rsp = '0;
    mst_req.b_ready = 1'b1; mst_req.r_ready = 1'b1;
    mst_rsp.aw_ready = 1'b1; mst_rsp.ar_ready = 1'b1; mst_rsp.w_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      slv_req[s].b_ready = 1'b1;
      slv_req[s].r_ready = 1'b1;
    end
    do_reset();
    chk("reset_eos", {31'd0, end_of_sim}, 32'd0);
    chk("reset_err", {31'd0, error}, 32'd0);
    chk("reset_cnt", err_cnt, 32'd0);

    // in-order write completion, then end-of-sim after 100 quiet cycles
    mst_aw(4'd3, 32'h0012_0010);
    slv_b(1);
    mst_b(4'd3, 2'b00);
    chk("t1_cnt", err_cnt, 32'd0);
    repeat (99) @(posedge clk);
    #1;
    chk("t1_eos_99", {31'd0, end_of_sim}, 32'd0);
    tick();
    chk("t1_eos_100", {31'd0, end_of_sim}, 32'd1);
    mst_aw(4'd3, 32'h0012_0010);
    chk("t1_eos_clr", {31'd0, end_of_sim}, 32'd0);

    // manager B before subordinate produced it
    do_reset();
    mst_aw(4'd3, 32'h0012_0010);
    mst_b(4'd3, 2'b00);
    chk("t2_cnt", err_cnt, 32'd1);
    chk("t2_err", {31'd0, error}, 32'd1);

    // two reads on id0, subordinates answer out of order, manager in order
    do_reset();
    mst_ar(4'd0, 32'h0021_0000, 8'd3);
    mst_ar(4'd0, 32'h0001_0000, 8'd0);
    slv_r_last(2);
    slv_r_last(0);
    repeat (3) mst_r(4'd0, 1'b0);
    mst_r(4'd0, 1'b1);
    mst_r(4'd0, 1'b1);
    chk("t3_inorder_cnt", err_cnt, 32'd0);
    chk("t3_inorder_err", {31'd0, error}, 32'd0);

    // same, manager order swapped: short last (BadLen), then 4 beats against
    // len 0 (first non-last beat and the last beat both BadLen)
    do_reset();
    mst_ar(4'd0, 32'h0021_0000, 8'd3);
    mst_ar(4'd0, 32'h0001_0000, 8'd0);
    slv_r_last(2);
    slv_r_last(0);
    mst_r(4'd0, 1'b1);
    repeat (3) mst_r(4'd0, 1'b0);
    mst_r(4'd0, 1'b1);
    chk("t3_swapped_cnt", err_cnt, 32'd3);

    // burst one beat short
    do_reset();
    mst_ar(4'd1, 32'h0001_0000, 8'd3);
    slv_r_last(0);
    mst_r(4'd1, 1'b0);
    mst_r(4'd1, 1'b0);
    mst_r(4'd1, 1'b1);
    chk("t4_cnt", err_cnt, 32'd1);
    chk("t4_err", {31'd0, error}, 32'd1);

    // unmapped address: DECERR accepted, OKAY rejected
    do_reset();
    mst_aw(4'd2, 32'h0050_0000);
    mst_b(4'd2, 2'b11);
    chk("t5_decerr_cnt", err_cnt, 32'd0);
    mst_aw(4'd2, 32'h0050_0000);
    mst_b(4'd2, 2'b00);
    chk("t5_okay_cnt", err_cnt, 32'd1);

    // subordinate B and manager B in the same cycle: pre-increment value is 0
    do_reset();
    mst_aw(4'd4, 32'h0011_0000);
    slv_rsp[1].b_valid = 1'b1;
    mst_rsp.b.id = 4'd4; mst_rsp.b.resp = 2'b00; mst_rsp.b_valid = 1'b1;
    tick();
    slv_rsp[1].b_valid = 1'b0; mst_rsp.b_valid = 1'b0;
    chk("same_cycle_cnt", err_cnt, 32'd1);
    mst_aw(4'd4, 32'h0011_0000);
    mst_b(4'd4, 2'b00);
    chk("same_cycle_later_cnt", err_cnt, 32'd1);

    // 33rd push to one ID overflows the 32-deep FIFO
    do_reset();
    repeat (32) mst_aw(4'd7, 32'h0000_1000);
    chk("ovf_full_cnt", err_cnt, 32'd0);
    mst_aw(4'd7, 32'h0000_1000);
    chk("ovf_cnt", err_cnt, 32'd1);

    // B with nothing outstanding, then a one-cycle reset
    do_reset();
    mst_b(4'd5, 2'b00);
    chk("t6_cnt", err_cnt, 32'd1);
    chk("t6_err", {31'd0, error}, 32'd1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    chk("t6_rst_cnt", err_cnt, 32'd0);
    chk("t6_rst_err", {31'd0, error}, 32'd0);
    chk("t6_rst_eos", {31'd0, end_of_sim}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
